x_uart_tx_frame: RTL and testbench



---
 rtl/x_uart_tx_frame.sv | 120 ++++++++++++
 tb/tb_x_uart_tx_frame.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/x_uart_tx_frame.sv
// UART transmitter: valid/ready byte capture, optional parity, 1 or 2 stop bits.
// Supports gapless back-to-back frames; o_tx is registered and decoded from the next state.
module x_uart_tx_frame #(
  parameter int p_clk_hz    = 12000000,
  parameter int p_baud      = 115200,
  parameter int p_data_bits = 8,
  parameter int p_parity    = 0,
  parameter int p_stop_bits = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [p_data_bits-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_busy
);
  localparam int P  = p_clk_hz / p_baud;
  localparam int TW = (P >= 2) ? $clog2(P) : 1;
  localparam int BW = (p_data_bits >= 2) ? $clog2(p_data_bits) : 1;

  if (p_data_bits < 5 || p_data_bits > 9) begin : g_bad_data_bits
    $error("x_uart_tx_frame: p_data_bits must be 5..9");
  end
  if (p_parity < 0 || p_parity > 2) begin : g_bad_parity
    $error("x_uart_tx_frame: p_parity must be 0, 1 or 2");
  end
  if (p_stop_bits != 1 && p_stop_bits != 2) begin : g_bad_stop_bits
    $error("x_uart_tx_frame: p_stop_bits must be 1 or 2");
  end
  if (P < 2) begin : g_bad_period
    $error("x_uart_tx_frame: p_clk_hz/p_baud must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state, state_nx;
  logic [TW-1:0]          timer, timer_nx;
  logic [BW-1:0]          bit_cnt, bit_nx;
  logic                   stop_cnt, stop_nx;
  logic [p_data_bits-1:0] hold;
  logic                   par_bit, par_nx;
  logic                   tx, tx_nx;
  logic                   bit_end, last_stop, xfer;

  assign bit_end   = (state != S_IDLE) && (timer == TW'(P - 1));
  assign last_stop = (p_stop_bits == 1) || stop_cnt;
  assign o_ready   = (state == S_IDLE) || ((state == S_STOP) && last_stop && bit_end);
  assign xfer      = i_valid && o_ready;
  assign par_nx    = (p_parity == 1) ? ~^i_data : ^i_data;
  assign o_busy    = (state != S_IDLE);
  assign o_tx      = tx;

  always_comb begin
    state_nx = state;
    bit_nx   = bit_cnt;
    stop_nx  = stop_cnt;
    timer_nx = (state == S_IDLE || bit_end) ? '0 : timer + 1'b1;
    case (state)
      S_IDLE:  if (xfer) state_nx = S_START;
      S_START: if (bit_end) begin
        state_nx = S_DATA;
        bit_nx   = '0;
      end
      S_DATA: if (bit_end) begin
        if (bit_cnt == BW'(p_data_bits - 1)) begin
          state_nx = (p_parity != 0) ? S_PARITY : S_STOP;
          stop_nx  = 1'b0;
        end else begin
          bit_nx = bit_cnt + 1'b1;
        end
      end
      S_PARITY: if (bit_end) begin
        state_nx = S_STOP;
        stop_nx  = 1'b0;
      end
      S_STOP: if (bit_end) begin
        if (last_stop) state_nx = xfer ? S_START : S_IDLE;
        else           stop_nx  = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase

    // line level follows the state we are about to enter, so o_tx can be a flop
    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = hold[bit_nx];
      S_PARITY: tx_nx = par_bit;
      default:  tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      hold     <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      bit_cnt  <= bit_nx;
      stop_cnt <= stop_nx;
      tx       <= tx_nx;
      if (xfer) begin
        hold    <= i_data;
        par_bit <= par_nx;
      end
    end
  end
endmodule

// File: tb/tb_x_uart_tx_frame.sv
// Bench for x_uart_tx_frame: three configs (8N1, 7E2, 7O2) at P=10 with a per-cycle line scoreboard.
module tb_x_uart_tx_frame;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] dbus;
  logic [2:0] vld;
  wire  [2:0] rdy, txl, bsy;
  int         n_tot = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int DB  = (k == 0) ? 8 : 7;
    localparam int PAR = (k == 0) ? 0 : (k == 1) ? 2 : 1;
    localparam int SB  = (k == 0) ? 1 : 2;
    localparam int FL  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

    x_uart_tx_frame #(
      .p_clk_hz(1000000), .p_baud(100000),
      .p_data_bits(DB), .p_parity(PAR), .p_stop_bits(SB)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(dbus[DB-1:0]), .i_valid(vld[k]),
      .o_ready(rdy[k]), .o_tx(txl[k]), .o_busy(bsy[k])
    );

    // expected line level per cycle; empty queue means idle
    logic q[$];
    bit   armed;

    always @(negedge clk) begin : mdl
      logic        et, eb, er;
      logic [11:0] fr;
      et = (q.size() != 0) ? q[0] : 1'b1;
      eb = (q.size() != 0);
      er = (q.size() <= 1);
      if (armed) begin
        chk($sformatf("u%0d_tx", k),    32'(txl[k]), 32'(et));
        chk($sformatf("u%0d_busy", k),  32'(bsy[k]), 32'(eb));
        chk($sformatf("u%0d_ready", k), 32'(rdy[k]), 32'(er));
      end
      if (q.size() != 0) void'(q.pop_front());
      if (!rst_n) begin
        q.delete();
        armed = 1'b1;
      end else if (vld[k] && er) begin
        fr    = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < DB; i++) fr[1+i] = dbus[i];
        if (PAR != 0) fr[1+DB] = (PAR == 1) ? ~^dbus[DB-1:0] : ^dbus[DB-1:0];
        for (int b = 0; b < FL; b++)
          for (int c = 0; c < 10; c++) q.push_back(fr[b]);
      end
    end
  end

  task automatic wait_rdy(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rdy[k]) begin ok = 1'b1; break; end
    end
    chk("rdy_wait", 32'(ok), 32'd1);
  endtask

  // returns at posedge+1 of the cycle after the transfer
  task automatic send(input int k, input logic [8:0] d);
    @(posedge clk); #1;
    vld[k] = 1'b1;
    dbus   = d;
    wait_rdy(k);
    @(posedge clk); #1;
    vld[k] = 1'b0;
  endtask

  task automatic count_busy(input int k, output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bsy[k]) break;
      n++;
    end
  endtask

  // samples nb line bits near mid-bit, starting just after a transfer
  task automatic sample_frame(input int k, input int nb, output logic [11:0] v);
    v = '0;
    repeat (5) @(negedge clk);
    v[0] = txl[k];
    for (int b = 1; b < nb; b++) begin
      repeat (10) @(negedge clk);
      v[b] = txl[k];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [11:0] v;
    rst_n = 1'b0;
    vld   = '0;
    dbus  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (50) @(posedge clk);
    #1;
    chk("idle_tx",    32'(txl), 32'h7);
    chk("idle_ready", 32'(rdy), 32'h7);
    chk("idle_busy",  32'(bsy), 32'h0);

    // 8N1 A5: pattern, then length on a second frame
    send(0, 9'h0A5);
    chk("a5_start", 32'(txl[0]), 32'd0);
    sample_frame(0, 10, v);
    chk("a5_bits", 32'(v[9:0]), 32'h34A);
    send(0, 9'h0A5);
    count_busy(0, n);
    chk("a5_len", n, 100);

    // 7E2 51: parity bit 1, 110-cycle frame
    send(1, 9'h051);
    sample_frame(1, 11, v);
    chk("e51_par",  32'(v[8]), 32'd1);
    chk("e51_bits", 32'(v[10:0]), 32'h7A2);
    send(1, 9'h051);
    count_busy(1, n);
    chk("e51_len", n, 110);

    // 7O2 50: parity bit 1
    send(2, 9'h050);
    sample_frame(2, 11, v);
    chk("o50_par",  32'(v[8]), 32'd1);
    chk("o50_bits", 32'(v[10:0]), 32'h7A0);
    send(2, 9'h050);
    count_busy(2, n);
    chk("o50_len", n, 110);

    // back-to-back with valid held, data changed mid-frame
    @(posedge clk); #1;
    vld[0] = 1'b1;
    dbus   = 9'h000;
    wait_rdy(0);
    @(posedge clk); #1;
    dbus = 9'h0FF;
    wait_rdy(0);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    dbus   = 9'h05A;
    chk("b2b_busy",  32'(bsy[0]), 32'd1);
    chk("b2b_start", 32'(txl[0]), 32'd0);
    count_busy(0, n);
    chk("b2b_len", n, 100);

    // reset at cycle 35 of a 0F frame, then a clean 3C frame
    send(0, 9'h00F);
    repeat (34) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_tx",    32'(txl[0]), 32'd1);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_busy",  32'(bsy[0]), 32'd0);
    send(0, 9'h03C);
    sample_frame(0, 10, v);
    chk("3c_bits", 32'(v[9:0]), 32'h278);
    count_busy(0, n);

    // one-cycle valid pulse while busy must be ignored
    send(0, 9'h096);
    repeat (30) @(posedge clk);
    #1;
    vld[0] = 1'b1;
    dbus   = 9'h011;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    count_busy(0, n);
    chk("wd_len", n, 69);
    repeat (30) @(posedge clk);
    #1;
    chk("wd_idle", 32'(bsy[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
